lru_replacement_unit: RTL and testbench

Replacement-policy helper for the 4-way turn-key cache of the SM4 encryptor. It holds true-LRU ordering state for four ways and reports the least-recently-used way as the victim. It accepts up to two access notifications per cycle: a lookup port and a read/write port. It also contains the combinational 4-to-2 priority encoder that turns the per-way CAM hit vector into a way index.

---
 rtl/lru_replacement_unit_if.sv | 26 ++
 rtl/lru_replacement_unit.sv | 85 ++++++++
 tb/tb_lru_replacement_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/lru_replacement_unit_if.sv
// Bus between the turn-key cache and its LRU replacement unit: access
// notifications, the victim way, the CAM hit encoder and a rank debug view.
interface lru_replacement_unit_if;
    // The access ports are valid-only and have no ready signal. The unit
    // accepts and applies every access whose v*_i is high at a rising edge.
    // access*_i is ignored while its v*_i is low.
    logic [1:0] access1_i;
    logic       v1_i;
    logic [1:0] access2_i;
    logic       v2_i;
    logic [1:0] replace_which_o;
    logic [3:0] hit_i;
    logic [1:0] hit_idx_o;
    logic       hit_any_o;
    logic [7:0] rank_dbg_o;

    modport master (
        output access1_i, v1_i, access2_i, v2_i, hit_i,
        input  replace_which_o, hit_idx_o, hit_any_o, rank_dbg_o
    );

    modport slave (
        input  access1_i, v1_i, access2_i, v2_i, hit_i,
        output replace_which_o, hit_idx_o, hit_any_o, rank_dbg_o
    );
endinterface

// File: rtl/lru_replacement_unit.sv
// True-LRU state for a 4-way cache plus the hit-vector priority encoder.
// Define LRU_RECORDER_DUAL_PORT_EN to enable the second (read/write) access port.
module lru_replacement_unit (
    input  logic                  clk_i,
    input  logic                  reset_i,
    lru_replacement_unit_if.slave bus
);
    typedef logic [3:0][1:0] rank_t;

    localparam rank_t RESET_RANKS = {2'd3, 2'd2, 2'd1, 2'd0};

    rank_t rank_q;
    rank_t rank_after1;
    rank_t rank_next;

    // Ranks above the touched way slide down one step; the touched way becomes
    // MRU. Touching the MRU way therefore leaves the order unchanged.
    function automatic rank_t touch(input rank_t r, input logic [1:0] a);
        rank_t n;
        n = r;
        for (int w = 0; w < 4; w++) begin
            if (r[w] > r[a]) begin
                n[w] = r[w] - 2'd1;
            end
        end
        n[a] = 2'd3;
        return n;
    endfunction

    always_comb begin
        rank_after1 = rank_q;
        if (bus.v1_i) begin
            rank_after1 = touch(rank_q, bus.access1_i);
        end
    end

`ifdef LRU_RECORDER_DUAL_PORT_EN
    // Port 2 is applied to the order produced by port 1, so it ends as MRU.
    always_comb begin
        rank_next = rank_after1;
        if (bus.v2_i) begin
            rank_next = touch(rank_after1, bus.access2_i);
        end
    end
`else
    logic unused_port2;
    assign unused_port2 = ^{bus.access2_i, bus.v2_i};

    always_comb begin
        rank_next = rank_after1;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rank_q <= RESET_RANKS;
        end else begin
            rank_q <= rank_next;
        end
    end

    // Victim comes from registered state only; the cache loops it back into
    // access1_i within the same cycle.
    always_comb begin
        bus.replace_which_o = 2'd0;
        for (int w = 0; w < 4; w++) begin
            if (rank_q[w] == 2'd0) begin
                bus.replace_which_o = 2'(w);
            end
        end
    end

    // Scan from the top so the lowest set bit is the last to write.
    always_comb begin
        bus.hit_idx_o = 2'd0;
        for (int w = 3; w >= 0; w--) begin
            if (bus.hit_i[w]) begin
                bus.hit_idx_o = 2'(w);
            end
        end
    end

    assign bus.hit_any_o  = |bus.hit_i;
    assign bus.rank_dbg_o = rank_q;
endmodule

// File: tb/tb_lru_replacement_unit.sv
// Directed table-driven bench for lru_replacement_unit (victim, ranks, encoder).
module tb_lru_replacement_unit;
  `ifdef LRU_RECORDER_DUAL_PORT_EN
  localparam bit DUAL = 1'b1;
  `else
  localparam bit DUAL = 1'b0;
  `endif

  typedef struct {
    logic       rst;
    logic       v1;
    logic [1:0] a1;
    logic       v2;
    logic [1:0] a2;
    logic [1:0] exp_victim;
    logic [7:0] exp_ranks;
  } vec_t;

  typedef struct {
    logic [3:0] hit;
    logic [1:0] exp_idx;
    logic       exp_any;
  } enc_t;

  logic clk;
  logic rst;
  int total;
  int bad;
  vec_t vecs[$];
  enc_t encs[$];
  logic [9:0] exp_q[$];

  lru_replacement_unit_if bus ();

  lru_replacement_unit dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic r, input logic v1, input logic [1:0] a1,
                         input logic v2, input logic [1:0] a2,
                         input logic [1:0] ev, input logic [7:0] er);
    vec_t v;
    v.rst = r; v.v1 = v1; v.a1 = a1; v.v2 = v2; v.a2 = a2;
    v.exp_victim = ev; v.exp_ranks = er;
    vecs.push_back(v);
  endtask

  task automatic add_enc(input logic [3:0] h, input logic [1:0] idx, input logic any);
    enc_t e;
    e.hit = h; e.exp_idx = idx; e.exp_any = any;
    encs.push_back(e);
  endtask

  // driver: set inputs on the falling edge, let one rising edge pass
  task automatic drive_cycle(input logic r, input logic v1, input logic [1:0] a1,
                             input logic v2, input logic [1:0] a2);
    @(negedge clk);
    rst = r;
    bus.v1_i = v1; bus.access1_i = a1;
    bus.v2_i = v2; bus.access2_i = a2;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name);
    logic [9:0] e;
    e = exp_q.pop_front();
    check({name, " victim"}, {6'd0, bus.replace_which_o}, {6'd0, e[9:8]});
    check({name, " ranks"}, bus.rank_dbg_o, e[7:0]);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.v1_i = 1'b0; bus.access1_i = 2'd0;
    bus.v2_i = 1'b0; bus.access2_i = 2'd0;
    bus.hit_i = 4'd0;

    // Ranks packed as {rank3, rank2, rank1, rank0}.
    add_vec(1, 0, 0, 0, 0, 2'd0, 8'he4);  // reset
    add_vec(0, 0, 0, 0, 0, 2'd0, 8'he4);  // idle
    add_vec(0, 0, 3, 0, 2, 2'd0, 8'he4);  // idle, don't-care addresses
    add_vec(0, 1, 0, 0, 0, 2'd1, 8'h93);  // touch 0 -> {3,0,1,2}
    add_vec(0, 1, 1, 0, 0, 2'd2, 8'h4e);  // touch 1 -> {2,3,0,1}
    add_vec(0, 1, 2, 0, 0, 2'd3, 8'h39);  // touch 2 -> {1,2,3,0}
    add_vec(0, 1, 3, 0, 0, 2'd0, 8'he4);  // touch 3 -> {0,1,2,3}
    add_vec(0, 1, 3, 0, 0, 2'd0, 8'he4);  // touch MRU: no change
    add_vec(1, 0, 0, 0, 0, 2'd0, 8'he4);
    // dual 2 then 1: {0,3,2,1}; single-port build sees only touch 2: {0,1,3,2}
    add_vec(0, 1, 2, 1, 1, 2'd0, DUAL ? 8'h6c : 8'hb4);
    add_vec(0, 1, 0, 0, 0, DUAL ? 2'd3 : 2'd1, DUAL ? 8'h1b : 8'h63);
    add_vec(1, 0, 0, 0, 0, 2'd0, 8'he4);
    add_vec(0, 1, 0, 1, 0, 2'd1, 8'h93);  // same-way dual
    add_vec(1, 0, 0, 0, 0, 2'd0, 8'he4);
    add_vec(0, 1, 0, 0, 0, 2'd1, 8'h93);
    add_vec(0, 1, 1, 0, 0, 2'd2, 8'h4e);
    add_vec(1, 1, 0, 0, 0, 2'd0, 8'he4);  // reset beats access
    add_vec(0, 0, 0, 1, 2, 2'd0, DUAL ? 8'hb4 : 8'he4);  // port 2 alone
    add_vec(0, 0, 0, 1, 0, DUAL ? 2'd1 : 2'd0, DUAL ? 8'h63 : 8'he4);

    add_enc(4'b0000, 2'd0, 1'b0);
    add_enc(4'b1000, 2'd3, 1'b1);
    add_enc(4'b0100, 2'd2, 1'b1);
    add_enc(4'b1010, 2'd1, 1'b1);
    add_enc(4'b1111, 2'd0, 1'b1);
    add_enc(4'b0110, 2'd1, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back({vecs[i].exp_victim, vecs[i].exp_ranks});
      drive_cycle(vecs[i].rst, vecs[i].v1, vecs[i].a1, vecs[i].v2, vecs[i].a2);
      check_state($sformatf("vec%0d", i));
    end

    // Victim must not move before the edge while an access is presented.
    drive_cycle(1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.v1_i = 1'b1; bus.access1_i = 2'd0;
    bus.v2_i = 1'b1; bus.access2_i = 2'd1;
    #1;
    check("no_comb_path victim", {6'd0, bus.replace_which_o}, 8'd0);
    check("no_comb_path ranks", bus.rank_dbg_o, 8'he4);
    @(posedge clk);
    #1;
    // dual 0 then 1: {2,3,0,1}; single: {3,0,1,2}
    exp_q.push_back(DUAL ? {2'd2, 8'h4e} : {2'd1, 8'h93});
    check_state("after_edge");
    bus.v1_i = 1'b0; bus.v2_i = 1'b0;

    // Encoder is combinational and independent of reset.
    rst = 1'b1;
    for (int i = 0; i < encs.size(); i++) begin
      bus.hit_i = encs[i].hit;
      #1;
      check($sformatf("enc%0d idx", i), {6'd0, bus.hit_idx_o}, {6'd0, encs[i].exp_idx});
      check($sformatf("enc%0d any", i), {7'd0, bus.hit_any_o}, {7'd0, encs[i].exp_any});
    end
    rst = 1'b0;

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d expected entries left, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
